// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word and the memory arbiter state encoding,
// kept here so monitors can decode the arbiter state without reaching into it.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port; round-robin on ties.
// Latency: request cycle N -> mem command N+1; resp is combinational with mem_resp; one IDLE cycle between accesses.
module mem_arbiter
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        i_read,
    input  rv32i_word   i_address,
    output logic        i_resp,
    output rv32i_word   i_rdata,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byte_enable,
    input  rv32i_word   d_address,
    input  rv32i_word   d_wdata,
    output logic        d_resp,
    output rv32i_word   d_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output rv32i_word   mem_address,
    output rv32i_word   mem_wdata,
    input  logic        mem_resp,
    input  rv32i_word   mem_rdata
);

    arb_state_t state_q, state_d;
    logic       write_q, write_d;
    logic [3:0] be_q, be_d;
    rv32i_word  addr_q, addr_d;
    rv32i_word  wdata_q, wdata_d;
    logic       last_data_q, last_data_d;   // 1 = data was served most recently

    logic       d_req;
    logic       grant_data;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_data_d = last_data_q;

        d_req      = d_read | d_write;
        grant_data = d_req && (!i_read || !last_data_q);

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d = SERVE_D;
                    write_d = d_write;      // read+write together resolves to write
                    be_d    = d_byte_enable;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                end else if (i_read) begin
                    state_d = SERVE_I;
                    write_d = 1'b0;
                    be_d    = 4'b1111;
                    addr_d  = i_address;
                    wdata_d = '0;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    state_d     = IDLE;
                    last_data_d = 1'b0;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    state_d     = IDLE;
                    last_data_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_data_q <= last_data_d;
        end
    end

    // Port payload comes only from the latches, and only while serving.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_address     = '0;
        mem_wdata       = '0;
        if (state_q == SERVE_I || state_q == SERVE_D) begin
            mem_read        = !write_q;
            mem_write       = write_q;
            mem_byte_enable = be_q;
            mem_address     = addr_q;
            mem_wdata       = wdata_q;
        end
    end

    assign i_resp  = (state_q == SERVE_I) && mem_resp;
    assign d_resp  = (state_q == SERVE_D) && mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table for the listed scenarios, then
// protocol-respecting random traffic against a transaction-level reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic        i_resp;
    logic [31:0] i_rdata;
    logic        d_read, d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_address, d_wdata;
    logic        d_resp;
    logic [31:0] d_rdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        mr;
        logic        mw;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ir;
        logic        dr;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } out_t;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        mresp;
        logic [31:0] mrdata;
        out_t        exp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    function automatic vec_t row(
        input logic r, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [3:0] dbe,
        input logic [31:0] da, input logic [31:0] dwd,
        input logic mresp, input logic [31:0] mrd,
        input logic emr, input logic emw, input logic [3:0] ebe,
        input logic [31:0] ea, input logic [31:0] ewd,
        input logic eir, input logic edr);
        vec_t v;
        v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dbe = dbe;
        v.da = da; v.dwd = dwd; v.mresp = mresp; v.mrdata = mrd;
        v.exp.mr = emr; v.exp.mw = emw; v.exp.be = ebe; v.exp.addr = ea;
        v.exp.wdata = ewd; v.exp.ir = eir; v.exp.dr = edr;
        v.exp.irdata = mrd; v.exp.drdata = mrd;
        return v;
    endfunction

    // Write data is only defined for writes and for the idle (all-zero) port.
    task automatic check(input out_t exp, input string name);
        out_t act;
        out_t e;
        act = '{mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
                i_resp, d_resp, i_rdata, d_rdata};
        e = exp;
        if (e.mr && !e.mw) e.wdata = act.wdata;
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t got mr=%b mw=%b be=%h a=%h wd=%h ir=%b dr=%b ird=%h drd=%h want mr=%b mw=%b be=%h a=%h wd=%h ir=%b dr=%b ird=%h drd=%h",
                     name, $time, act.mr, act.mw, act.be, act.addr, act.wdata, act.ir, act.dr,
                     act.irdata, act.drdata, e.mr, e.mw, e.be, e.addr, e.wdata, e.ir, e.dr,
                     e.irdata, e.drdata);
        end
    endtask

    vec_t tbl[$];

    // Reference model: which requester currently owns the port and the transaction it captured.
    typedef struct {
        logic        is_data;
        logic        write;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic m_busy;
    logic m_last_data;
    txn_t m_cur;

    function automatic out_t model_out();
        out_t o;
        o = '0;
        if (m_busy) begin
            o.mr    = !m_cur.write;
            o.mw    = m_cur.write;
            o.be    = m_cur.be;
            o.addr  = m_cur.addr;
            o.wdata = m_cur.wdata;
            o.ir    = mem_resp && !m_cur.is_data;
            o.dr    = mem_resp && m_cur.is_data;
        end
        o.irdata = mem_rdata;
        o.drdata = mem_rdata;
        return o;
    endfunction

    task automatic model_step();
        logic want_d;
        logic take_d;
        want_d = d_read || d_write;
        if (rst) begin
            m_busy = 1'b0;
            m_last_data = 1'b0;
        end else if (m_busy) begin
            if (mem_resp) begin
                m_busy = 1'b0;
                m_last_data = m_cur.is_data;
            end
        end else if (want_d || i_read) begin
            take_d = want_d && !(i_read && m_last_data);
            m_busy = 1'b1;
            if (take_d)
                m_cur = '{1'b1, d_write, d_byte_enable, d_address, d_wdata};
            else
                m_cur = '{1'b0, 1'b0, 4'hF, i_address, 32'h0};
        end
    endtask

    logic        i_pend, d_pend;
    out_t        exp_r;

    initial begin
        rst = 1'b1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
        d_byte_enable = 0; d_address = 0; d_wdata = 0; mem_resp = 0; mem_rdata = 0;
        m_busy = 0; m_last_data = 0; m_cur = '{0, 0, 0, 0, 0};

        //            rst ir ia       dr dw be    da          dwd           mr rdata          | mr mw be    addr         wdata        ir dr
        tbl.push_back(row(1, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h60, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h60, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         1, 0, 4'hF, 32'h60,   32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h60, 0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         1, 0, 4'hF, 32'h60,   32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h60, 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h00A00093,  1, 0, 4'hF, 32'h60,   32'h0,        1, 0));
        tbl.push_back(row(0, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(1, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h64, 1, 0, 4'hF, 32'h1000, 32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h64, 1, 0, 4'hF, 32'h1000, 32'h0,        1, 32'h11223344,  1, 0, 4'hF, 32'h1000, 32'h0,        0, 1));
        tbl.push_back(row(0, 1, 32'h64, 1, 0, 4'hF, 32'h1004, 32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h64, 1, 0, 4'hF, 32'h1004, 32'h0,        1, 32'h55667788,  1, 0, 4'hF, 32'h64,   32'h0,        1, 0));
        tbl.push_back(row(0, 0, 32'h0,  1, 0, 4'hF, 32'h1004, 32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  1, 0, 4'hF, 32'h1004, 32'h0,        1, 32'h99AABBCC,  1, 0, 4'hF, 32'h1004, 32'h0,        0, 1));
        tbl.push_back(row(0, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  0, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  0, 1, 4'hF, 32'h3000, 32'h12345678, 0, 32'h0,         0, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 0));
        tbl.push_back(row(0, 0, 32'h0,  0, 1, 4'hF, 32'h3000, 32'h12345678, 1, 32'h0,         0, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 1));
        tbl.push_back(row(0, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  1, 1, 4'hC, 32'h40,   32'hCAFEF00D, 0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  1, 1, 4'hC, 32'h40,   32'hCAFEF00D, 1, 32'h0,         0, 1, 4'hC, 32'h40,   32'hCAFEF00D, 0, 1));
        tbl.push_back(row(0, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  1, 0, 4'hF, 32'h80,   32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  1, 0, 4'hF, 32'h80,   32'h0,        0, 32'h0,         1, 0, 4'hF, 32'h80,   32'h0,        0, 0));
        tbl.push_back(row(1, 0, 32'h0,  1, 0, 4'hF, 32'h80,   32'h0,        0, 32'h0,         1, 0, 4'hF, 32'h80,   32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h77777777,  0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h88888888,  0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        // Last-served was data before the reset; reset must hand the next tie to data again.
        tbl.push_back(row(0, 1, 32'h64, 1, 0, 4'hF, 32'h1000, 32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h64, 1, 0, 4'hF, 32'h1000, 32'h0,        0, 32'h0,         1, 0, 4'hF, 32'h1000, 32'h0,        0, 0));
        tbl.push_back(row(0, 1, 32'h64, 1, 0, 4'hF, 32'h1000, 32'h0,        1, 32'h0,         1, 0, 4'hF, 32'h1000, 32'h0,        0, 1));
        tbl.push_back(row(0, 0, 32'h0,  0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0));

        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            rst = tbl[k].rst; i_read = tbl[k].ir; i_address = tbl[k].ia;
            d_read = tbl[k].dr; d_write = tbl[k].dw; d_byte_enable = tbl[k].dbe;
            d_address = tbl[k].da; d_wdata = tbl[k].dwd;
            mem_resp = tbl[k].mresp; mem_rdata = tbl[k].mrdata;
            @(negedge clk);
            check(tbl[k].exp, $sformatf("vec%0d", k));
            @(posedge clk);
            #1;
        end

        // Random phase: start from a clean reset so model and DUT agree.
        rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        @(posedge clk);
        #1;
        m_busy = 0; m_last_data = 0;
        i_pend = 0; d_pend = 0;

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                i_address = $urandom & 32'hFFFF_FFFC;
            end else if (!i_pend) begin
                i_address = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                int kind;
                d_pend = 1'b1;
                kind = $urandom_range(0, 2);
                d_read  = (kind != 1);
                d_write = (kind != 0);
                d_byte_enable = 4'($urandom);
                d_address = $urandom;
                d_wdata = $urandom;
            end else if (!d_pend) begin
                d_read = 0; d_write = 0;
                d_byte_enable = 4'($urandom);
                d_address = $urandom;
                d_wdata = $urandom;
            end
            i_read = i_pend;
            mem_resp = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;

            @(negedge clk);
            exp_r = model_out();
            check(exp_r, "random");
            if (exp_r.ir) i_pend = 1'b0;
            if (exp_r.dr) d_pend = 1'b0;
            if (!d_pend) begin
                d_read = 0; d_write = 0;
            end
            model_step();
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clocking SHALL be fixed: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_read  input  1  instruction-fetch read request.
REQ-005 i_address  input  32 (rv32i_word)  fetch address.
REQ-006 i_resp  output  1  fetch complete, one-cycle pulse.
REQ-007 i_rdata  output  32  fetch data, valid when i_resp=1.
REQ-008 d_read  input  1  data read request.
REQ-009 d_write  input  1  data write request.
REQ-010 d_byte_enable  input  4  data write byte mask.
REQ-011 d_address  input  32  data address.
REQ-012 d_wdata  input  32  data write value.
REQ-013 d_resp  output  1  data access complete, one-cycle pulse.
REQ-014 d_rdata  output  32  data read value, valid when d_resp=1.
REQ-015 mem_read, mem_write  output  1 each  shared memory port commands.
REQ-016 mem_byte_enable  output  4; mem_address, mem_wdata  output  32  shared port payload.
REQ-017 mem_resp  input  1; mem_rdata  input  32  shared port response.

Function
REQ-018 FSM SHALL have states IDLE, SERVE_I, SERVE_D.
REQ-019 In IDLE with any request, arbiter SHALL latch winner's command, address, byte mask, wdata into internal registers and enter SERVE_I/SERVE_D next cycle.
REQ-020 Memory outputs SHALL be driven only from latched registers, only in SERVE_I/SERVE_D; in IDLE all mem_* outputs SHALL be 0.
REQ-021 SERVE_I SHALL drive mem_read=1, mem_write=0, mem_byte_enable=4'b1111, mem_address=latched i_address.
REQ-022 SERVE_D SHALL drive mem_read/mem_write per latched command, mem_byte_enable=latched d_byte_enable, mem_address/mem_wdata from latch.
REQ-023 Both d_read and d_write asserted SHALL be treated as a write.
REQ-024 Tie (fetch and data both requesting in IDLE) SHALL be round-robin: grant the requester not served last; last-served bit resets to "fetch", so first tie goes to data.
REQ-025 Single requester SHALL be granted regardless of last-served bit.
REQ-026 Grant SHALL hold until mem_resp=1; requester input changes during service SHALL be ignored.
REQ-027 On mem_resp=1 in SERVE_x, x_resp SHALL pulse same cycle (combinational), other resp SHALL stay 0, FSM SHALL return to IDLE next cycle, last-served bit SHALL update.
REQ-028 i_rdata and d_rdata SHALL both equal mem_rdata combinationally; only resp qualifies validity.
REQ-029 mem_resp in IDLE SHALL be ignored (no resp pulse, no state change).
REQ-030 Minimum latency SHALL be: request seen cycle N, mem_* asserted N+1, resp earliest N+1 if memory responds same cycle; next arbitration in IDLE at cycle after resp, so back-to-back accesses have a one-cycle IDLE gap.
REQ-031 Requesters SHALL hold requests stable until their resp; a request dropped before grant is never serviced.

Reset
REQ-032 rst=1 SHALL force IDLE, clear latches to 0, last-served to fetch; all mem_* outputs, i_resp, d_resp SHALL be 0 on the cycle after rst sampled high.
REQ-033 Reset mid-transaction SHALL abandon the access with no resp pulse; a subsequent stale mem_resp SHALL be ignored per REQ-029.

Structure
REQ-034 rv32i_word SHALL come from rv32i_types; the arbiter state enum SHALL be defined in rv32i_types as a shared typedef for monitor visibility.
REQ-035 Single module, no sub-module; instantiated at CPU top between control/datapath requesters and the memory port.

Verification
REQ-036 Fetch only: i_read=1, i_address=0x60, memory responds after 3 cycles with 0x00A00093 -> mem_read=1 address 0x60 be=4'hF, i_resp pulses once with i_rdata=0x00A00093, d_resp=0.
REQ-037 Tie after reset: i_read=1 @0x64, d_read=1 @0x1000 same cycle -> data served first, then fetch; repeated tie next time -> fetch first.
REQ-038 Write: d_write=1, d_address=0x2004, d_wdata=0xDEADBEEF, be=4'b0011 -> mem_write=1 with those values latched even if inputs change during wait; d_resp one pulse.
REQ-039 Read+write both high -> treated as write, mem_read=0.
REQ-040 Reset mid-SERVE_D, then mem_resp=1 while IDLE -> no resp pulses, all mem_* = 0.
